ca_row_engine: RTL and testbench
================================

Name: ca_row_engine

Overview:
Parametrised 1-D elementary cellular-automaton engine, successor to the fixed 9-switch automaton datapath.
- Holds a CELLS-wide generation register and applies any 8-bit Wolfram rule per generation.
- Boundary mode is runtime-selectable: null (zero) or toroidal (wrap).
- Streams each generation as one pixel row (x, y, colour, plot) into the VGA framebuffer writer, top row first, until ROWS generations are drawn.

Parameters:
CELLS, 160, cells per generation = pixels per row
ROWS, 120, generations drawn per frame
SEED_W, 9, width of seed input, placed centred in the cell register
STEP_DIV, 0, idle cycles inserted between finished row and next step (0 = back-to-back)
XW, 8, x coordinate width (must satisfy 2**XW >= CELLS)
YW, 7, y coordinate width (must satisfy 2**YW >= ROWS)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  asynchronous active-low reset
load_seed  in  1  single-cycle pulse: load seed, restart frame
seed  in  SEED_W  initial pattern
load_rule  in  1  single-cycle pulse: capture rule_in
rule_in  in  8  Wolfram rule number
wrap_mode  in  1  1 = toroidal boundary, 0 = null boundary
run  in  1  1 = advance; 0 = freeze in WAIT
x  out  XW  pixel x
y  out  YW  pixel y (= generation index)
colour  out  3  3'b111 if cell alive, else 3'b000
plot  out  1  pixel write strobe
done  out  1  frame complete
gen_count  out  YW  generations computed since last seed

Behaviour:
- Reset values: cells=0, rule=8'd30, state=IDLE, all outputs 0.
- Seed placement: base = CELLS/2 - SEED_W/2 (integer division); cells[base+k] = seed[k]; all other cells 0.
- Cell i is drawn at x=i.
- Neighbourhood of cell i is idx = {cells[i-1], cells[i], cells[i+1]}; next[i] = rule[idx].
- Out-of-range neighbour (i-1 < 0 or i+1 = CELLS):
  - wrap_mode=0: reads 0.
  - wrap_mode=1: reads cells[CELLS-1] or cells[0] respectively.
- wrap_mode is sampled at the STEP cycle.
- States: IDLE, DRAW, WAIT, STEP, HALT.
  - IDLE: plot=0. Leaves only on load_seed.
  - load_seed, sampled in any state: cells <= placed seed; row <= 0; xcnt <= 0; gen_count <= 0; done <= 0; next state DRAW. Overrides DRAW/STEP/WAIT in progress.
  - DRAW: one pixel per cycle; plot=1, x=xcnt, y=row, colour from cells[xcnt]. All outputs registered.
    - First plot appears 2 cycles after the edge sampling load_seed.
    - Exactly CELLS consecutive plot cycles per row.
    - After xcnt=CELLS-1: row==ROWS-1 -> HALT; otherwise -> WAIT.
  - WAIT: plot=0. Delay counter counts STEP_DIV cycles, advancing only while run=1; run=0 freezes the counter.
    - Counter reaching STEP_DIV with run=1 -> STEP.
    - STEP_DIV=0: go to STEP on the first cycle with run=1.
  - STEP: single cycle: cells <= next; row++; gen_count++; xcnt <= 0; -> DRAW.
  - HALT: done=1, plot=0; holds until load_seed.
- load_rule: rule <= rule_in on the sampling edge, in any state. Takes effect at the next STEP; an already-drawn row is never altered.
  - load_rule and load_seed in the same cycle: both take effect.
- No plot is ever emitted with x >= CELLS or y >= ROWS.
- Reset asserted mid-operation: immediately returns to reset values; plot drops asynchronously.

Decomposition:
- Package ca_pkg:
  - state enum (IDLE, DRAW, WAIT, STEP, HALT)
  - COL_ALIVE = 3'b111, COL_DEAD = 3'b000
  - RULE_RESET = 8'd30
  - function rule_lookup(rule, l, c, r)
- Sub-module ca_next_gen: purely combinational CELLS-wide next-generation array (rule, wrap_mode, cells -> next). Instantiated once.
- FSM, counters and pixel output registers stay in ca_row_engine.

Test Plan:
Bench parameters CELLS=16, ROWS=4, SEED_W=3, STEP_DIV=2 unless stated.
1. Reset: hold resetn=0 -> plot=0, done=0, x=0, y=0, gen_count=0. Release, run=1, no load_seed -> no plot for 100 cycles.
2. Rule 90 (load_rule, rule_in=8'd90), wrap_mode=0, seed=3'b010, pulse load_seed -> alive pixels are: y0 {8}; y1 {7,9}; y2 {6,10}; y3 {5,7,9,11}. Each row has 16 plots, 2 idle WAIT cycles between rows, then done=1, gen_count=3.
3. Wrap, ROWS=12, rule 8'd2, seed=3'b010 -> row r alive only at x=8-r for r<=8. Row 9: wrap_mode=1 gives x=15 alive; wrap_mode=0 gives all dead.
4. Pause: drop run in WAIT after y1 for 50 cycles -> zero plots and gen_count frozen at 1. Raise run -> STEP, then y2 drawn with identical pixels to scenario 2.
5. Restart: pulse load_seed while DRAW is at x=5 of y2 -> plot stops, then restarts at x=0, y=0 two cycles later; gen_count=0.
6. Rule change mid-frame: after y1 is drawn in scenario 2, load rule 8'd0 -> y2 and y3 all dead, y0/y1 pixels unchanged, done=1 after y3.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton row engine.
package ca_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        WAIT,
        STEP,
        HALT
    } state_t;

    localparam logic [2:0] COL_ALIVE  = 3'b111;
    localparam logic [2:0] COL_DEAD   = 3'b000;
    localparam logic [7:0] RULE_RESET = 8'd30;

    // Wolfram rule: the neighbourhood {l,c,r} selects one bit of the rule number.
    function automatic logic rule_lookup(input logic [7:0] rule,
                                         input logic       l,
                                         input logic       c,
                                         input logic       r);
        return rule[{l, c, r}];
    endfunction

endpackage

// File: rtl/ca_next_gen.sv
// Combinational next-generation array for a 1-D elementary cellular automaton.
module ca_next_gen
    import ca_pkg::*;
#(
    parameter int CELLS = 160
) (
    input  logic [7:0]       rule,
    input  logic             wrap_mode,
    input  logic [CELLS-1:0] cells,
    output logic [CELLS-1:0] next_cells
);

    logic [CELLS-1:0] left_n;
    logic [CELLS-1:0] right_n;

    // Edge cells see the opposite end in toroidal mode and a dead cell otherwise.
    assign left_n  = {cells[CELLS-2:0], wrap_mode & cells[CELLS-1]};
    assign right_n = {wrap_mode & cells[0], cells[CELLS-1:1]};

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        assign next_cells[i] = rule_lookup(rule, left_n[i], cells[i], right_n[i]);
    end

endmodule

// File: rtl/ca_row_engine.sv
// Elementary CA engine: evolves a generation register and streams each generation as a pixel row.
module ca_row_engine
    import ca_pkg::*;
#(
    parameter int CELLS    = 160,
    parameter int ROWS     = 120,
    parameter int SEED_W   = 9,
    parameter int STEP_DIV = 0,
    parameter int XW       = 8,
    parameter int YW       = 7
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              load_seed,
    input  logic [SEED_W-1:0] seed,
    input  logic              load_rule,
    input  logic [7:0]        rule_in,
    input  logic              wrap_mode,
    input  logic              run,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              done,
    output logic [YW-1:0]     gen_count
);

    localparam int BASE = CELLS / 2 - SEED_W / 2;
    localparam int DW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = (STEP_DIV > 1) ? DW'(STEP_DIV - 1) : '0;

    state_t           state;
    state_t           state_n;
    logic [CELLS-1:0] cells;
    logic [CELLS-1:0] next_cells;
    logic [CELLS-1:0] placed;
    logic [7:0]       rule;
    logic [XW-1:0]    xcnt;
    logic [YW-1:0]    row;
    logic [DW-1:0]    div_cnt;
    logic             last_x;
    logic             last_row;
    logic             div_last;

    logic             s_valid;
    logic             s_alive;
    logic [XW-1:0]    s_x;
    logic [YW-1:0]    s_y;

    assign placed    = CELLS'(seed) << BASE;
    assign last_x    = (xcnt == XW'(CELLS - 1));
    assign last_row  = (row == YW'(ROWS - 1));
    assign div_last  = (div_cnt == DIV_LAST);
    assign gen_count = row;

    ca_next_gen #(.CELLS(CELLS)) u_next_gen (
        .rule       (rule),
        .wrap_mode  (wrap_mode),
        .cells      (cells),
        .next_cells (next_cells)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            DRAW:       if (last_x) state_n = last_row ? HALT : WAIT;
            WAIT:       if (run && div_last) state_n = STEP;
            STEP:       state_n = DRAW;
            IDLE, HALT: state_n = state;
            default:    state_n = IDLE;
        endcase
        if (load_seed) state_n = DRAW;
    end

    // Generation register, rule and counters; a seed load overrides any frame in progress.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cells   <= '0;
            rule    <= RULE_RESET;
            xcnt    <= '0;
            row     <= '0;
            div_cnt <= '0;
            done    <= 1'b0;
        end else begin
            if (load_rule) rule <= rule_in;
            if (load_seed) begin
                cells   <= placed;
                xcnt    <= '0;
                row     <= '0;
                div_cnt <= '0;
                done    <= 1'b0;
            end else begin
                case (state)
                    DRAW: begin
                        div_cnt <= '0;
                        if (last_x) begin
                            xcnt <= '0;
                            if (last_row) done <= 1'b1;
                        end else begin
                            xcnt <= xcnt + XW'(1);
                        end
                    end
                    WAIT: if (run && !div_last) div_cnt <= div_cnt + DW'(1);
                    STEP: begin
                        cells <= next_cells;
                        row   <= row + YW'(1);
                        xcnt  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Two-stage pixel pipeline: cell fetch, then the registered framebuffer outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s_valid <= 1'b0;
            s_alive <= 1'b0;
            s_x     <= '0;
            s_y     <= '0;
            plot    <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= COL_DEAD;
        end else if (load_seed) begin
            s_valid <= 1'b0;
            s_alive <= 1'b0;
            plot    <= 1'b0;
            colour  <= COL_DEAD;
        end else begin
            s_valid <= (state == DRAW);
            s_alive <= (state == DRAW) && cells[xcnt];
            if (state == DRAW) begin
                s_x <= xcnt;
                s_y <= row;
            end
            plot   <= s_valid;
            colour <= (s_valid && s_alive) ? COL_ALIVE : COL_DEAD;
            if (s_valid) begin
                x <= s_x;
                y <= s_y;
            end
        end
    end

endmodule

// File: tb/tb_ca_row_engine.sv
// Bench for ca_row_engine: two instances (4 and 12 rows) share stimulus and are checked against a generation-level model.
module tb_ca_row_engine;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       load_seed = 1'b0;
    logic [2:0] seed = '0;
    logic       load_rule = 1'b0;
    logic [7:0] rule_in = '0;
    logic       wrap_mode = 1'b0;
    logic       run = 1'b0;

    logic [3:0] x_a, x_b;
    logic [1:0] y_a, gen_a;
    logic [3:0] y_b, gen_b;
    logic [2:0] col_a, col_b;
    logic       plot_a, plot_b, done_a, done_b;

    logic       d_plot [2];
    logic       d_done [2];
    logic [3:0] d_x    [2];
    logic [3:0] d_y    [2];
    logic [3:0] d_gen  [2];
    logic [2:0] d_col  [2];

    int tests = 0;
    int fails = 0;

    // Model state, one slot per instance
    logic [15:0] m_cells     [2] = '{default: '0};
    bit          m_expecting [2] = '{default: 1'b0};
    bit          m_finished  [2] = '{default: 1'b0};
    bit          m_need_step [2] = '{default: 1'b0};
    int          m_x         [2] = '{default: 0};
    int          m_y         [2] = '{default: 0};
    int          pix_seen    [2] = '{default: 0};
    int          idle_run    [2] = '{default: 0};
    logic [15:0] cap         [2][12];
    int          row_plots   [2][12];
    int          gap_len     [2][12];
    logic [7:0]  m_rule = 8'd30;
    logic        m_wrap = 1'b0;

    always #5 clk = ~clk;

    ca_row_engine #(.CELLS(16), .ROWS(4), .SEED_W(3), .STEP_DIV(2), .XW(4), .YW(2)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .load_seed(load_seed), .seed(seed),
        .load_rule(load_rule), .rule_in(rule_in), .wrap_mode(wrap_mode), .run(run),
        .x(x_a), .y(y_a), .colour(col_a), .plot(plot_a), .done(done_a), .gen_count(gen_a)
    );

    ca_row_engine #(.CELLS(16), .ROWS(12), .SEED_W(3), .STEP_DIV(2), .XW(4), .YW(4)) dut_b (
        .CLOCK_50(clk), .resetn(resetn), .load_seed(load_seed), .seed(seed),
        .load_rule(load_rule), .rule_in(rule_in), .wrap_mode(wrap_mode), .run(run),
        .x(x_b), .y(y_b), .colour(col_b), .plot(plot_b), .done(done_b), .gen_count(gen_b)
    );

    assign d_plot[0] = plot_a;          assign d_plot[1] = plot_b;
    assign d_done[0] = done_a;          assign d_done[1] = done_b;
    assign d_x[0]    = x_a;             assign d_x[1]    = x_b;
    assign d_y[0]    = {2'b00, y_a};    assign d_y[1]    = y_b;
    assign d_gen[0]  = {2'b00, gen_a};  assign d_gen[1]  = gen_b;
    assign d_col[0]  = col_a;           assign d_col[1]  = col_b;

    function automatic int rows_of(input int d);
        return (d == 0) ? 4 : 12;
    endfunction

    // One generation from the rule definition: bit (4l+2c+r) of the rule number.
    function automatic logic [15:0] next_gen(input logic [15:0] c, input logic [7:0] rule, input logic wrap);
        logic [15:0] n;
        int l, m, r;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            m = int'(c[i]);
            if (i == 0) l = wrap ? int'(c[15]) : 0;
            else        l = int'(c[i-1]);
            if (i == 15) r = wrap ? int'(c[0]) : 0;
            else         r = int'(c[i+1]);
            n[i] = rule[l * 4 + m * 2 + r];
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input int d, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d", name, d, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit ls, input bit [2:0] s, input bit lr, input bit [7:0] r,
                                 input bit w, input bit rn);
        @(posedge clk); #1;
        load_seed = ls; seed = s; load_rule = lr; rule_in = r; wrap_mode = w; run = rn;
        @(posedge clk); #1;
        load_seed = 1'b0; load_rule = 1'b0;
    endtask

    task automatic waitPix(input int d, input int target, input int budget);
        int n = 0;
        while (pix_seen[d] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (pix_seen[d] < target) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_pixels dut%0d: got %0d pixels, expected %0d", d, pix_seen[d], target);
        end
    endtask

    task automatic waitDone(input int d, input int budget);
        int n = 0;
        while (!m_finished[d] && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (!m_finished[d]) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_frame dut%0d: got %0d pixels, frame never completed", d, pix_seen[d]);
        end
    endtask

    // Compare process: check outputs produced by the previous edge, then absorb the inputs the next edge samples.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                m_expecting[d] = 1'b0;
                m_finished[d]  = 1'b0;
                m_need_step[d] = 1'b0;
            end else begin
                if (m_expecting[d]) begin
                    if (d_plot[d]) begin
                        if (m_need_step[d]) begin
                            m_cells[d]     = next_gen(m_cells[d], m_rule, m_wrap);
                            m_y[d]         = m_y[d] + 1;
                            m_x[d]         = 0;
                            m_need_step[d] = 1'b0;
                        end
                        checkOutput("pix_x", d, d_x[d], m_x[d]);
                        checkOutput("pix_y", d, d_y[d], m_y[d]);
                        checkOutput("colour", d, d_col[d], m_cells[d][m_x[d]] ? 7 : 0);
                        checkOutput("gen_count", d, d_gen[d], m_y[d]);
                        if (m_y[d] < rows_of(d) - 1) checkOutput("done_low", d, d_done[d], 0);
                        cap[d][m_y[d]][m_x[d]] = (d_col[d] == 3'b111);
                        row_plots[d][m_y[d]]++;
                        if (m_x[d] == 0) gap_len[d][m_y[d]] = idle_run[d];
                        idle_run[d] = 0;
                        pix_seen[d]++;
                        if (m_x[d] == 15) begin
                            if (m_y[d] == rows_of(d) - 1) begin
                                m_expecting[d] = 1'b0;
                                m_finished[d]  = 1'b1;
                            end else begin
                                m_need_step[d] = 1'b1;
                            end
                        end else begin
                            m_x[d] = m_x[d] + 1;
                        end
                    end else begin
                        idle_run[d]++;
                    end
                end else begin
                    checkOutput("no_plot", d, d_plot[d], 0);
                    if (m_finished[d]) checkOutput("done_high", d, d_done[d], 1);
                end
                if (load_seed) begin
                    m_cells[d]     = 16'(seed) << 7;
                    m_expecting[d] = 1'b1;
                    m_finished[d]  = 1'b0;
                    m_need_step[d] = 1'b0;
                    m_x[d]         = 0;
                    m_y[d]         = 0;
                    pix_seen[d]    = 0;
                    idle_run[d]    = 0;
                    for (int r = 0; r < 12; r++) begin
                        cap[d][r]       = '0;
                        row_plots[d][r] = 0;
                        gap_len[d][r]   = 0;
                    end
                end
            end
        end
        if (!resetn)        m_rule = 8'd30;
        else if (load_rule) m_rule = rule_in;
        m_wrap = wrap_mode;
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_plot", d, d_plot[d], 0);
            checkOutput("rst_done", d, d_done[d], 0);
            checkOutput("rst_x", d, d_x[d], 0);
            checkOutput("rst_y", d, d_y[d], 0);
            checkOutput("rst_gen", d, d_gen[d], 0);
        end
        resetn = 1'b1;
        run = 1'b1;
        repeat (100) @(posedge clk);
        checkOutput("idle_plots", 0, pix_seen[0], 0);
        checkOutput("idle_plots", 1, pix_seen[1], 0);

        // Rule 90, null boundary
        applyStimulus(0, 3'b000, 1, 8'd90, 0, 1);
        applyStimulus(1, 3'b010, 0, 8'd90, 0, 1);
        waitDone(0, 400);
        @(negedge clk);
        checkOutput("r90_y0", 0, cap[0][0], 16'h0100);
        checkOutput("r90_y1", 0, cap[0][1], 16'h0280);
        checkOutput("r90_y2", 0, cap[0][2], 16'h0440);
        checkOutput("r90_y3", 0, cap[0][3], 16'h0AA0);
        for (int r = 0; r < 4; r++) checkOutput("row_plots", 0, row_plots[0][r], 16);
        for (int r = 1; r < 4; r++) checkOutput("row_gap", 0, gap_len[0][r], 3);
        checkOutput("r90_gen", 0, d_gen[0], 3);
        checkOutput("r90_done", 0, d_done[0], 1);

        // Rule 2 travelling left; rule and seed loaded in the same cycle
        applyStimulus(1, 3'b010, 1, 8'd2, 1, 1);
        waitDone(1, 1000);
        @(negedge clk);
        checkOutput("r2w_y3", 1, cap[1][3], 16'h0020);
        checkOutput("r2w_y8", 1, cap[1][8], 16'h0001);
        checkOutput("r2w_y9", 1, cap[1][9], 16'h8000);
        checkOutput("r2w_y11", 1, cap[1][11], 16'h2000);
        checkOutput("r2w_gen", 1, d_gen[1], 11);
        applyStimulus(1, 3'b010, 0, 8'd2, 0, 1);
        waitDone(1, 1000);
        @(negedge clk);
        checkOutput("r2n_y8", 1, cap[1][8], 16'h0001);
        checkOutput("r2n_y9", 1, cap[1][9], 16'h0000);

        // Pause in WAIT after y1
        applyStimulus(0, 3'b000, 1, 8'd90, 0, 1);
        applyStimulus(1, 3'b010, 0, 8'd90, 0, 1);
        waitPix(0, 17, 200);
        run = 1'b0;
        waitPix(0, 32, 200);
        repeat (5) @(posedge clk);
        repeat (50) @(posedge clk);
        @(negedge clk);
        checkOutput("pause_plots", 0, pix_seen[0], 32);
        checkOutput("pause_gen", 0, d_gen[0], 1);
        checkOutput("pause_plot", 0, d_plot[0], 0);
        run = 1'b1;
        waitDone(0, 400);
        @(negedge clk);
        checkOutput("pause_y2", 0, cap[0][2], 16'h0440);
        checkOutput("pause_y3", 0, cap[0][3], 16'h0AA0);

        // Rule 0 loaded mid-frame while paused after y1
        applyStimulus(1, 3'b010, 0, 8'd90, 0, 1);
        waitPix(0, 17, 200);
        run = 1'b0;
        waitPix(0, 32, 200);
        repeat (10) @(posedge clk);
        applyStimulus(0, 3'b000, 1, 8'd0, 0, 0);
        run = 1'b1;
        waitDone(0, 400);
        @(negedge clk);
        checkOutput("r0_y0", 0, cap[0][0], 16'h0100);
        checkOutput("r0_y1", 0, cap[0][1], 16'h0280);
        checkOutput("r0_y2", 0, cap[0][2], 16'h0000);
        checkOutput("r0_y3", 0, cap[0][3], 16'h0000);
        checkOutput("r0_done", 0, d_done[0], 1);

        // Restart while y2 is being drawn
        applyStimulus(0, 3'b000, 1, 8'd90, 0, 1);
        applyStimulus(1, 3'b010, 0, 8'd90, 0, 1);
        waitPix(0, 38, 400);
        applyStimulus(1, 3'b010, 0, 8'd90, 0, 1);
        @(negedge clk);
        checkOutput("rs_plot0", 0, d_plot[0], 0);
        checkOutput("rs_gen", 0, d_gen[0], 0);
        @(negedge clk);
        checkOutput("rs_plot1", 0, d_plot[0], 0);
        @(negedge clk);
        checkOutput("rs_plot2", 0, d_plot[0], 1);
        checkOutput("rs_x", 0, d_x[0], 0);
        checkOutput("rs_y", 0, d_y[0], 0);

        // Asynchronous reset in the middle of a row
        waitPix(0, 5, 100);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_plot", 0, d_plot[0], 0);
        checkOutput("async_plot", 1, d_plot[1], 0);
        checkOutput("async_gen", 0, d_gen[0], 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_plot", 0, d_plot[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
